// File: rtl/cdc_rd_sched_pkg.sv
// Shared definitions for the read-domain result scheduler:
// state encoding, default widths and zero constants.
package cdc_rd_sched_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_RUN  = 2'b01,
        ST_DONE = 2'b10
    } state_e;

    localparam int DSIZE_DEF = 8;
    localparam int CSIZE_DEF = 13;

    localparam logic [DSIZE_DEF-1:0] DATA_ZERO = {DSIZE_DEF{1'b0}};
    localparam logic [CSIZE_DEF-1:0] CNT_ZERO  = {CSIZE_DEF{1'b0}};

endpackage

// File: rtl/cdc_rd_out_reg.sv
// Output holding register: loads on pop, drops on accept, holds while
// downstream stalls, and clears on abort.
module cdc_rd_out_reg
    import cdc_rd_sched_pkg::*;
#(
    parameter int DSIZE = DSIZE_DEF
) (
    input  logic             clk2,
    input  logic             rst_n,
    input  logic             clr,
    input  logic             pop,
    input  logic             out_ready,
    input  logic [DSIZE-1:0] rdata,
    output logic             out_valid,
    output logic [DSIZE-1:0] out
);

    logic             out_valid_d, out_valid_q;
    logic [DSIZE-1:0] out_d, out_q;

    // next-value selection; a pop in the same cycle as an accept replaces the data
    always_comb begin
        out_valid_d = out_valid_q;
        out_d       = out_q;
        if (clr) begin
            out_valid_d = 1'b0;
            out_d       = {DSIZE{1'b0}};
        end else if (pop) begin
            out_valid_d = 1'b1;
            out_d       = rdata;
        end else if (out_valid_q && out_ready) begin
            out_valid_d = 1'b0;
            out_d       = {DSIZE{1'b0}};
        end else begin
            out_valid_d = out_valid_q;
            out_d       = out_q;
        end
    end

    // holding register
    always_ff @(posedge clk2 or negedge rst_n) begin
        if (!rst_n) begin
            out_valid_q <= 1'b0;
            out_q       <= {DSIZE{1'b0}};
        end else begin
            out_valid_q <= out_valid_d;
            out_q       <= out_d;
        end
    end

    assign out_valid = out_valid_q;
    assign out       = out_q;

endmodule

// File: rtl/cdc_rd_sched.sv
// Read-domain scheduler: pops exactly total_num results from a first-word
// fall-through async FIFO and hands them downstream over valid/ready.
module cdc_rd_sched
    import cdc_rd_sched_pkg::*;
#(
    parameter int DSIZE = DSIZE_DEF,
    parameter int CSIZE = CSIZE_DEF
) (
    input  logic             clk2,
    input  logic             rst_n,
    input  logic             start,
    input  logic             flush,
    input  logic [CSIZE-1:0] total_num,
    input  logic             rempty,
    input  logic [DSIZE-1:0] rdata,
    input  logic             out_ready,
    output logic             rinc,
    output logic             out_valid,
    output logic [DSIZE-1:0] out,
    output logic             busy,
    output logic             done,
    output logic [CSIZE-1:0] xfer_cnt
);

    localparam logic [CSIZE-1:0] CNT_ONE = {{(CSIZE-1){1'b0}}, 1'b1};

    state_e           state_d, state_q;
    logic [CSIZE-1:0] total_d, total_q;
    logic [CSIZE-1:0] pop_cnt_d, pop_cnt_q;
    logic [CSIZE-1:0] xfer_cnt_d, xfer_cnt_q;
    logic             out_valid_s;
    logic             pop_s;
    logic             accept_s;

    // an abort suppresses both the pop and the accept count of its cycle
    assign pop_s = (state_q == ST_RUN) && !rempty && (pop_cnt_q < total_q)
                   && (!out_valid_s || out_ready) && !flush;
    assign accept_s = (state_q == ST_RUN) && out_valid_s && out_ready && !flush;

    // FSM next state and counter updates
    always_comb begin
        state_d    = state_q;
        total_d    = total_q;
        pop_cnt_d  = pop_cnt_q;
        xfer_cnt_d = xfer_cnt_q;
        case (state_q)
            ST_IDLE: begin
                if (start && !flush) begin
                    total_d    = total_num;
                    pop_cnt_d  = {CSIZE{1'b0}};
                    xfer_cnt_d = {CSIZE{1'b0}};
                    state_d    = (total_num == {CSIZE{1'b0}}) ? ST_DONE : ST_RUN;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_RUN: begin
                if (flush) begin
                    state_d = ST_IDLE;
                end else begin
                    if (pop_s) begin
                        pop_cnt_d = pop_cnt_q + CNT_ONE;
                    end else begin
                        pop_cnt_d = pop_cnt_q;
                    end
                    if (accept_s) begin
                        xfer_cnt_d = xfer_cnt_q + CNT_ONE;
                    end else begin
                        xfer_cnt_d = xfer_cnt_q;
                    end
                    // completes on the edge that registers the last accept
                    state_d = (xfer_cnt_d == total_q) ? ST_DONE : ST_RUN;
                end
            end
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    // state and counter registers
    always_ff @(posedge clk2 or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_IDLE;
            total_q    <= {CSIZE{1'b0}};
            pop_cnt_q  <= {CSIZE{1'b0}};
            xfer_cnt_q <= {CSIZE{1'b0}};
        end else begin
            state_q    <= state_d;
            total_q    <= total_d;
            pop_cnt_q  <= pop_cnt_d;
            xfer_cnt_q <= xfer_cnt_d;
        end
    end

    cdc_rd_out_reg #(
        .DSIZE(DSIZE)
    ) u_out_reg (
        .clk2      (clk2),
        .rst_n     (rst_n),
        .clr       (flush),
        .pop       (pop_s),
        .out_ready (out_ready),
        .rdata     (rdata),
        .out_valid (out_valid_s),
        .out       (out)
    );

    assign rinc      = pop_s;
    assign out_valid = out_valid_s;
    assign busy      = (state_q == ST_RUN);
    assign done      = (state_q == ST_DONE);
    assign xfer_cnt  = xfer_cnt_q;

endmodule

// File: tb/tb_cdc_rd_sched.sv
// Directed bench for cdc_rd_sched with a small first-word fall-through FIFO model.
module tb_cdc_rd_sched;

    localparam int DW = 8;
    localparam int CW = 13;

    logic          clk2      = 1'b0;
    logic          rst_n     = 1'b1;
    logic          start     = 1'b0;
    logic          flush     = 1'b0;
    logic          out_ready = 1'b0;
    logic          fifo_clr  = 1'b0;
    logic [CW-1:0] total_num = '0;
    logic          rempty;
    logic [DW-1:0] rdata;
    logic          rinc;
    logic          out_valid;
    logic [DW-1:0] out;
    logic          busy;
    logic          done;
    logic [CW-1:0] xfer_cnt;

    logic [DW-1:0] mem [64];
    logic [7:0]    rd_ptr = 8'd0;
    logic [7:0]    wr_ptr = 8'd0;
    int            total  = 0;
    int            bad    = 0;

    cdc_rd_sched #(.DSIZE(DW), .CSIZE(CW)) dut (
        .clk2      (clk2),
        .rst_n     (rst_n),
        .start     (start),
        .flush     (flush),
        .total_num (total_num),
        .rempty    (rempty),
        .rdata     (rdata),
        .out_ready (out_ready),
        .rinc      (rinc),
        .out_valid (out_valid),
        .out       (out),
        .busy      (busy),
        .done      (done),
        .xfer_cnt  (xfer_cnt)
    );

    always #5 clk2 = ~clk2;

    assign rempty = (rd_ptr == wr_ptr);
    assign rdata  = mem[rd_ptr[5:0]];

    // FIFO read side
    always @(posedge clk2) begin
        if (fifo_clr) rd_ptr <= wr_ptr;
        else if (rinc) rd_ptr <= rd_ptr + 8'd1;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic push(input logic [DW-1:0] v);
        mem[wr_ptr[5:0]] = v;
        wr_ptr = wr_ptr + 8'd1;
    endtask

    task automatic clear_fifo();
        @(negedge clk2); fifo_clr = 1'b1;
        @(negedge clk2); fifo_clr = 1'b0;
    endtask

    task automatic start_job(input logic [CW-1:0] t);
        @(negedge clk2);
        start = 1'b1;
        total_num = t;
        #1;
        chk("idle_rinc", rinc, 0);
    endtask

    // full-rate job of n results with out_ready held high, data base+1..base+n
    task automatic stream(input logic [DW-1:0] base, input int n);
        for (int i = 0; i <= n; i++) begin
            @(negedge clk2); start = 1'b0; #1;
            chk("st_rinc", rinc, (i < n) ? 1 : 0);
            chk("st_valid", out_valid, (i > 0) ? 1 : 0);
            chk("st_out", out, (i > 0) ? (base + i) : 0);
            chk("st_busy", busy, 1);
            chk("st_nodone", done, 0);
        end
        @(negedge clk2); #1;
        chk("st_done", done, 1);
        chk("st_xfer", xfer_cnt, n);
        chk("st_valid_off", out_valid, 0);
        chk("st_busy_off", busy, 0);
        @(negedge clk2); #1;
        chk("st_done_pulse", done, 0);
    endtask

    initial begin
        // reset state
        #2 rst_n = 1'b0;
        #1;
        chk("rst_valid", out_valid, 0);
        chk("rst_out", out, 0);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_xfer", xfer_cnt, 0);
        chk("rst_rinc", rinc, 0);
        repeat (2) @(negedge clk2);
        rst_n = 1'b1;

        // five results at full rate
        for (int i = 1; i <= 5; i++) push(8'h10 + DW'(i));
        out_ready = 1'b1;
        start_job(13'd5);
        stream(8'h10, 5);

        // out_ready toggling, 3 of 6 entries consumed
        for (int i = 1; i <= 6; i++) push(8'h20 + DW'(i));
        start_job(13'd3);
        for (int j = 0; j <= 6; j++) begin
            @(negedge clk2);
            start = 1'b0;
            out_ready = (j % 2 == 0);
            #1;
            chk("tg_rinc", rinc, ((j % 2 == 0) && (j <= 4)) ? 1 : 0);
            chk("tg_valid", out_valid, (j > 0) ? 1 : 0);
            chk("tg_out", out, (j > 0) ? (8'h21 + (j - 1) / 2) : 0);
            chk("tg_nodone", done, 0);
        end
        @(negedge clk2); out_ready = 1'b1; #1;
        chk("tg_done", done, 1);
        chk("tg_xfer", xfer_cnt, 3);
        chk("tg_left", 32'(wr_ptr - rd_ptr), 3);
        @(negedge clk2); #1;
        chk("tg_done_once", done, 0);
        clear_fifo();

        // stall on an empty FIFO for 10 cycles
        start_job(13'd4);
        for (int k = 0; k < 10; k++) begin
            @(negedge clk2); start = 1'b0; #1;
            chk("stall_busy", busy, 1);
            chk("stall_rinc", rinc, 0);
            chk("stall_valid", out_valid, 0);
        end
        @(posedge clk2); #1;
        for (int i = 1; i <= 4; i++) push(8'h30 + DW'(i));
        stream(8'h30, 4);

        // flush after two accepts of eight
        for (int i = 1; i <= 8; i++) push(8'h40 + DW'(i));
        start_job(13'd8);
        for (int i = 0; i <= 2; i++) begin
            @(negedge clk2); start = 1'b0; #1;
            chk("fl_rinc", rinc, 1);
            chk("fl_out", out, (i > 0) ? (8'h40 + i) : 0);
        end
        @(negedge clk2);
        flush = 1'b1;
        out_ready = 1'b0;
        #1;
        chk("fl_rinc_blk", rinc, 0);
        chk("fl_out_pre", out, 8'h43);
        @(negedge clk2); flush = 1'b0; #1;
        chk("fl_busy", busy, 0);
        chk("fl_valid", out_valid, 0);
        chk("fl_out_clr", out, 0);
        chk("fl_nodone", done, 0);
        chk("fl_xfer", xfer_cnt, 2);
        @(negedge clk2); #1;
        chk("fl_nodone2", done, 0);
        out_ready = 1'b1;
        clear_fifo();
        push(8'h55);
        start_job(13'd1);
        stream(8'h54, 1);

        // zero-length job never touches the FIFO
        push(8'h66);
        start_job(13'd0);
        @(negedge clk2); start = 1'b0; #1;
        chk("z_done", done, 1);
        chk("z_rinc", rinc, 0);
        chk("z_busy", busy, 0);
        @(negedge clk2); #1;
        chk("z_done_pulse", done, 0);
        chk("z_rinc2", rinc, 0);
        chk("z_left", 32'(wr_ptr - rd_ptr), 1);

        // asynchronous reset mid-job
        clear_fifo();
        for (int i = 1; i <= 6; i++) push(8'h70 + DW'(i));
        start_job(13'd6);
        for (int i = 0; i <= 3; i++) begin
            @(negedge clk2); start = 1'b0; #1;
        end
        @(posedge clk2); #1;
        chk("ar_xfer_pre", xfer_cnt, 3);
        #1 rst_n = 1'b0;
        #1;
        chk("ar_valid", out_valid, 0);
        chk("ar_out", out, 0);
        chk("ar_busy", busy, 0);
        chk("ar_done", done, 0);
        chk("ar_xfer", xfer_cnt, 0);
        chk("ar_rinc", rinc, 0);
        repeat (2) @(negedge clk2);
        rst_n = 1'b1;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk2); #1;
            chk("ar_idle_busy", busy, 0);
            chk("ar_idle_done", done, 0);
            chk("ar_idle_rinc", rinc, 0);
            chk("ar_idle_valid", out_valid, 0);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/cdc_rd_sched.md
CDC_RD_SCHED -- requirements
Module: cdc_rd_sched

Interface
REQ-001 Parameter DSIZE, default 8, data width of one ranked result.
REQ-002 Parameter CSIZE, default 13, width of the job length and counters.
REQ-003 Clock and reset: reset rst_n, asynchronous, active-low; clock clk2.
REQ-004 clk2  input  1  read-domain clock; all state updates on its rising edge.
REQ-005 rst_n  input  1  asynchronous active-low reset.
REQ-006 start  input  1  one-cycle job-start pulse; ignored unless in IDLE.
REQ-007 flush  input  1  synchronous abort; dominates start.
REQ-008 total_num  input  CSIZE  results in the job; sampled only on an accepted start.
REQ-009 rempty  input  1  async-FIFO empty flag, already in the clk2 domain.
REQ-010 rdata  input  DSIZE  FIFO head entry; valid whenever rempty=0 (first-word fall-through).
REQ-011 out_ready  input  1  downstream accepts out this cycle.
REQ-012 rinc  output  1  combinational FIFO pop strobe.
REQ-013 out_valid  output  1  out holds a result.
REQ-014 out  output  DSIZE  result data; 0 whenever out_valid=0.
REQ-015 busy  output  1  high in RUN.
REQ-016 done  output  1  one-cycle pulse on job completion.
REQ-017 xfer_cnt  output  CSIZE  results accepted downstream in current/last job.

Function
REQ-018 States IDLE, RUN, DONE; encoding from the shared package.
REQ-019 IDLE: start=1, flush=0, total_num>0 -> RUN; latch total_num; clear pop_cnt and xfer_cnt.
REQ-020 IDLE: start=1, total_num=0 -> DONE directly; no FIFO access.
REQ-021 pop = (state==RUN) & ~rempty & (pop_cnt<total) & (~out_valid | out_ready) & ~flush; rinc = pop.
REQ-022 On pop: out<=rdata, out_valid<=1, pop_cnt+1; latency rdata->out exactly 1 clk2 cycle.
REQ-023 Accept = out_valid & out_ready; increments xfer_cnt.
REQ-024 Accept without pop: out_valid<=0, out<=0; accept with pop same cycle: out replaced, out_valid stays 1.
REQ-025 out_valid=1 & out_ready=0: out and out_valid held stable; no pop.
REQ-026 Throughput: one result per cycle while out_ready=1 and rempty=0.
REQ-027 RUN -> DONE in the cycle xfer_cnt reaches total (registered); done=1 in DONE only; DONE -> IDLE unconditionally.
REQ-028 Entries left in FIFO after pop_cnt==total are never popped.
REQ-029 rempty=1 in RUN: no pop, state held indefinitely; no timeout.
REQ-030 flush in RUN or DONE: next cycle IDLE, out_valid=0, out=0, no done; xfer_cnt retains value.
REQ-031 start while RUN/DONE ignored; total latch unchanged.
REQ-032 Counters CSIZE bits, unsigned, never wrap (bounded by total <= 2^CSIZE-1).

Reset
REQ-033 rst_n=0: state IDLE; out_valid, out, busy, done, xfer_cnt, pop_cnt, total = 0; rinc=0.
REQ-034 Reset mid-job discards the job; no done pulse is produced on release.

Structure
REQ-035 Shared package holds state enum, DSIZE/CSIZE defaults and zero constants.
REQ-036 One sub-module, cdc_rd_out_reg: output holding register with valid/ready hold logic; FSM and counters stay at top.

Verification
REQ-037 total_num=5, FIFO holds 5 entries 0x11..0x15, out_ready=1 -> rinc 5 consecutive cycles, out 0x11..0x15 on 5 consecutive cycles, done one cycle after last accept, xfer_cnt=5.
REQ-038 total_num=3, FIFO 6 entries, out_ready toggling 1,0,1,0,... -> exactly 3 pops, out stable during ready=0, 3 entries remain, done once.
REQ-039 total_num=4, FIFO empty for 10 cycles then filled -> busy=1, rinc=0, out_valid=0 throughout stall, then normal completion.
REQ-040 flush after 2 of 8 accepts -> IDLE next cycle, out_valid=0, no done, xfer_cnt=2; new start total_num=1 then completes.
REQ-041 start with total_num=0 -> done pulse 1 cycle later, rinc never asserted.
REQ-042 rst_n low mid-job (3 of 6 transferred) -> all outputs 0 asynchronously; after release stays IDLE until start.
